// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - two-port request/response bundle for the shared ALU arbiter
interface alu_share_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [6:0]  req_op0;
    logic [6:0]  req_op1;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic [3:0]  rsp_flags;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_hi, rsp_lo, rsp_flags
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_hi, rsp_lo, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters
// Optional macro ALU_SHARE_FIXED_PRIO_EN: port 0 always wins a tie instead of round-robin.
module alu_share_arbiter #(
    parameter int ALU_LAT  = 1,
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus,
    output logic [31:0]         alu_in1,
    output logic [31:0]         alu_in2,
    output logic [6:0]          alu_op,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         alu_hi,
    input  logic [31:0]         alu_lo,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_c,
    input  logic                alu_s,
    output logic                busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [1:0]       rsp_valid_q;
    logic [31:0]      result_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [3:0]       flags_q;

    logic             grant;
    logic             any_valid;
    logic [6:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_mult;

    always_comb begin
        any_valid = |bus.req_valid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant = ~bus.req_valid[0];
`else
        // On a tie take the port that did not win last time; otherwise the lone requester.
        grant = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
`endif
        sel_op   = grant ? bus.req_op1 : bus.req_op0;
        sel_a    = grant ? bus.req_a1  : bus.req_a0;
        sel_b    = grant ? bus.req_b1  : bus.req_b0;
        sel_mult = (sel_op == 7'b0000010) || (sel_op == 7'b0000001);
    end

    assign bus.req_ready  = (state == IDLE && any_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_hi     = hi_q;
    assign bus.rsp_lo     = lo_q;
    assign bus.rsp_flags  = flags_q;
    assign alu_in1        = a_q;
    assign alu_in2        = b_q;
    assign alu_op         = op_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cnt         <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= '0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        last_grant <= grant;
                        cnt        <= sel_mult ? CNT_W'(MULT_LAT - 1) : CNT_W'(ALU_LAT - 1);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        result_q    <= alu_result;
                        hi_q        <= alu_hi;
                        lo_q        <= alu_lo;
                        flags_q     <= {alu_z, alu_v, alu_c, alu_s};
                        rsp_valid_q <= last_grant ? 2'b10 : 2'b01;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    // Only the granted port's accept counts; the ALU operands stay parked until then.
                    if (bus.rsp_ready[last_grant]) begin
                        rsp_valid_q <= 2'b00;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_in1, alu_in2, alu_result, alu_hi, alu_lo;
    logic [6:0]  alu_op;
    logic        alu_z, alu_v, alu_c, alu_s, busy;
    logic [63:0] prod;
    int          passed = 0;
    int          total = 0;
    int          n;
    logic [1:0]  rr_exp [4];

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_hi(alu_hi), .alu_lo(alu_lo),
        .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .alu_s(alu_s),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Small reference ALU standing in for the shared datapath
    always_comb begin
        alu_result = '0;
        alu_hi     = '0;
        alu_lo     = '0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        prod       = '0;
        case (alu_op)
            7'b0000000: begin
                {alu_c, alu_result} = {1'b0, alu_in1} + {1'b0, alu_in2};
                alu_v = (alu_in1[31] == alu_in2[31]) && (alu_result[31] != alu_in1[31]);
            end
            7'b0000010: begin
                prod = $signed({{32{alu_in1[31]}}, alu_in1}) * $signed({{32{alu_in2[31]}}, alu_in2});
                {alu_hi, alu_lo} = prod;
                alu_result = prod[31:0];
            end
            7'b0000001: begin
                prod = {32'd0, alu_in1} * {32'd0, alu_in2};
                {alu_hi, alu_lo} = prod;
                alu_result = prod[31:0];
            end
            7'b0000100: alu_result = alu_in1 ^ alu_in2;
            default:    alu_result = '0;
        endcase
        alu_z = (alu_result == 32'd0);
        alu_s = alu_result[31];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (bus.rsp_valid == 2'b00 && cycles < 20);
    endtask

    initial begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        rr_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;

        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_req_ready", {30'd0, bus.req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("reset_alu_op", {25'd0, alu_op}, 32'd0);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single add on port 0
        bus.req_valid = 2'b01; bus.req_op0 = 7'b0000000;
        bus.req_a0 = 32'd5; bus.req_b0 = 32'd7; bus.rsp_ready = 2'b11;
        #1;
        chk("add_req_ready", {30'd0, bus.req_ready}, 32'h1);
        step();
        bus.req_valid = 2'b00;
        chk("add_busy", {31'd0, busy}, 32'd1);
        chk("add_alu_in1", alu_in1, 32'd5);
        chk("add_rsp_valid_early", {30'd0, bus.rsp_valid}, 32'd0);
        step();
        chk("add_rsp_valid", {30'd0, bus.rsp_valid}, 32'h1);
        chk("add_result", bus.rsp_result, 32'd12);
        chk("add_flags", {28'd0, bus.rsp_flags}, 32'h0);
        step();
        chk("add_done_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("add_done_busy", {31'd0, busy}, 32'd0);

        // Signed multiply on port 1
        bus.req_valid = 2'b10; bus.req_op1 = 7'b0000010;
        bus.req_a1 = 32'hFFFF_FFFD; bus.req_b1 = 32'd4;
        #1;
        chk("mult_req_ready", {30'd0, bus.req_ready}, 32'h2);
        step();
        bus.req_valid = 2'b00;
        wait_rsp(n);
        chk("mult_latency", n, 32'd4);
        chk("mult_rsp_valid", {30'd0, bus.rsp_valid}, 32'h2);
        chk("mult_hi", bus.rsp_hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.rsp_lo, 32'hFFFF_FFF4);
        chk("mult_flags", {28'd0, bus.rsp_flags}, 32'h1);
        step();
        chk("mult_done_busy", {31'd0, busy}, 32'd0);

        // Both ports requesting continuously
        bus.req_valid = 2'b11; bus.req_op0 = 7'b0000000; bus.req_op1 = 7'b0000000;
        bus.req_a0 = 32'd1; bus.req_b0 = 32'd1; bus.req_a1 = 32'd2; bus.req_b1 = 32'd2;
        #1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (bus.req_ready == 2'b00 && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("rr_grant%0d", t), {30'd0, bus.req_ready}, {30'd0, rr_exp[t]});
            step();
        end
        bus.req_valid = 2'b00;
        step();
        step();
        chk("rr_done_busy", {31'd0, busy}, 32'd0);

        // Back-pressure on port 0 while port 1 waits
        bus.req_valid = 2'b11; bus.req_op0 = 7'b0000100;
        bus.req_a0 = 32'hFF; bus.req_b0 = 32'hFF;
        bus.req_a1 = 32'd3; bus.req_b1 = 32'd4; bus.rsp_ready = 2'b10;
        #1;
        chk("bp_req_ready", {30'd0, bus.req_ready}, 32'h1);
        step();
        bus.req_valid = 2'b10;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid%0d", i), {30'd0, bus.rsp_valid}, 32'h1);
            chk($sformatf("bp_result%0d", i), bus.rsp_result, 32'd0);
            chk($sformatf("bp_flags%0d", i), {28'd0, bus.rsp_flags}, 32'h8);
            chk($sformatf("bp_req_ready%0d", i), {30'd0, bus.req_ready}, 32'h0);
            step();
        end
        bus.rsp_ready = 2'b01;
        step();
        chk("bp_accept_valid", {30'd0, bus.rsp_valid}, 32'h0);
        chk("bp_port1_grant", {30'd0, bus.req_ready}, 32'h2);
        step();
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
        step();
        chk("bp_port1_valid", {30'd0, bus.rsp_valid}, 32'h2);
        chk("bp_port1_result", bus.rsp_result, 32'd7);
        step();

        // Reset two cycles into a multiply
        bus.req_valid = 2'b01; bus.req_op0 = 7'b0000010;
        bus.req_a0 = 32'hFFFF_FFFD; bus.req_b0 = 32'd4;
        #1;
        chk("rst_req_ready", {30'd0, bus.req_ready}, 32'h1);
        step();
        bus.req_valid = 2'b00;
        step();
        step();
        chk("rst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_op", {25'd0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus.req_valid = 2'b11; bus.req_op0 = 7'b0000000; bus.req_op1 = 7'b0000000;
        bus.req_a0 = 32'd10; bus.req_b0 = 32'd20; bus.req_a1 = 32'd1; bus.req_b1 = 32'd1;
        #1;
        chk("post_rst_tie", {30'd0, bus.req_ready}, 32'h1);
        step();
        bus.req_valid = 2'b00;
        step();
        chk("post_rst_valid", {30'd0, bus.rsp_valid}, 32'h1);
        chk("post_rst_result", bus.rsp_result, 32'd30);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
